// File: rtl/spi_master.sv
// SPI mode 0 master and companion slave, 8-bit frames, single clock domain.
// Optional build macro: SPI_LSB_FIRST_EN -- when defined, both ends shift
// LSB first; otherwise MSB first. Frame timing is identical either way.

package spi_master_pkg;

`ifdef SPI_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   // Bit that goes on the wire first for a given shift register.
   function automatic logic lead_bit(input logic [7:0] b);
      return LSB_FIRST ? b[0] : b[7];
   endfunction

   // Shift register after its lead bit has been sent.
   function automatic logic [7:0] drop_lead(input logic [7:0] b);
      return LSB_FIRST ? (b >> 1) : (b << 1);
   endfunction

   // Shift register after taking in one received bit.
   function automatic logic [7:0] take_bit(input logic [7:0] b, input logic s);
      return LSB_FIRST ? {s, b[7:1]} : {b[6:0], s};
   endfunction

endpackage

module spi_master
   import spi_master_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic       cs
);

   localparam logic [7:0] DIV_MAX = 8'(HALF_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t     state, state_nx;
   logic [7:0] div;
   logic [2:0] bit_cnt;
   logic [7:0] tx_sr;
   logic [7:0] rx_sr;

   logic load, in_xfer, tick, fall, last, finish;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state: start only counts in IDLE, frame ends on the 8th falling sck.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = XFER;
         XFER:    if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control strobes decoded from state and the half-period divider.
   always_comb begin
      load    = (state == IDLE) && start;
      in_xfer = (state == XFER);
      tick    = in_xfer && (div == DIV_MAX);
      fall    = tick && sck;
      last    = fall && (bit_cnt == 3'd7);
      finish  = (state == DONE);
   end

   // Registered datapath: sck generation, shifting, cs and result capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs       <= 1'b1;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         data_out <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         div      <= '0;
         bit_cnt  <= '0;
      end else if (load) begin
         tx_sr   <= data_in;
         rx_sr   <= '0;
         cs      <= 1'b0;
         sck     <= 1'b0;
         mosi    <= lead_bit(data_in);
         div     <= '0;
         bit_cnt <= '0;
      end else if (tick) begin
         div <= '0;
         sck <= ~sck;
         if (fall) begin
            rx_sr   <= take_bit(rx_sr, miso);
            tx_sr   <= drop_lead(tx_sr);
            bit_cnt <= bit_cnt + 3'd1;
            mosi    <= last ? 1'b0 : lead_bit(drop_lead(tx_sr));
         end
      end else if (in_xfer) begin
         div <= div + 8'd1;
      end else if (finish) begin
         cs       <= 1'b1;
         data_out <= rx_sr;
      end
   end

endmodule

module spi_slave
   import spi_master_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       mosi,
   input  logic       cs,
   output logic       miso,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   logic       sck_q, cs_q;
   logic [7:0] tx_sr, rx_sr;
   logic [3:0] cnt;
   logic       sck_rise, sck_fall, cs_fall, cs_rise;

   // Edge detection against the previous clk-sampled values.
   always_comb begin
      sck_rise = sck & ~sck_q;
      sck_fall = ~sck & sck_q;
      cs_fall  = ~cs & cs_q;
      cs_rise  = cs & ~cs_q;
   end

   // Shift engine; the sample counter saturates so an over-long frame never
   // wraps back to a count of exactly eight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_q    <= 1'b0;
         cs_q     <= 1'b1;
         miso     <= 1'b0;
         data_out <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         cnt      <= '0;
      end else begin
         sck_q <= sck;
         cs_q  <= cs;
         if (cs) begin
            miso <= 1'b0;
            if (cs_rise && (cnt == 4'd8)) data_out <= rx_sr;
         end else if (cs_fall) begin
            tx_sr <= data_in;
            miso  <= lead_bit(data_in);
            cnt   <= '0;
         end else begin
            if (sck_rise) begin
               rx_sr <= take_bit(rx_sr, mosi);
               if (cnt != 4'hF) cnt <= cnt + 4'd1;
            end
            if (sck_fall) begin
               tx_sr <= drop_lead(tx_sr);
               miso  <= lead_bit(drop_lead(tx_sr));
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master with spi_slave loopback at HALF_PERIOD 1 and 3.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start1 = 1'b0, start3 = 1'b0;
   logic [7:0] m_din = '0, s_din = '0;

   logic       sck1, mosi1, miso1, cs1;
   logic [7:0] mdo1, sdo1;
   logic       sck3, mosi3, miso3, cs3;
   logic [7:0] mdo3, sdo3;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        mon_en = 1'b0;

   logic       v_sel = 1'b0;
   logic       v_sck, v_mosi, v_miso, v_cs;
   logic [7:0] v_mdo, v_sdo;

   always #5 clk = ~clk;

   spi_master #(.HALF_PERIOD(1)) u_m1 (
      .clk(clk), .rst(rst), .start(start1), .data_in(m_din), .data_out(mdo1),
      .sck(sck1), .mosi(mosi1), .miso(miso1), .cs(cs1));
   spi_slave u_s1 (
      .clk(clk), .rst(rst), .sck(sck1), .mosi(mosi1), .cs(cs1), .miso(miso1),
      .data_in(s_din), .data_out(sdo1));

   spi_master #(.HALF_PERIOD(3)) u_m3 (
      .clk(clk), .rst(rst), .start(start3), .data_in(m_din), .data_out(mdo3),
      .sck(sck3), .mosi(mosi3), .miso(miso3), .cs(cs3));
   spi_slave u_s3 (
      .clk(clk), .rst(rst), .sck(sck3), .mosi(mosi3), .cs(cs3), .miso(miso3),
      .data_in(s_din), .data_out(sdo3));

   always_comb begin
      v_sck  = v_sel ? sck3  : sck1;
      v_mosi = v_sel ? mosi3 : mosi1;
      v_miso = v_sel ? miso3 : miso1;
      v_cs   = v_sel ? cs3   : cs1;
      v_mdo  = v_sel ? mdo3  : mdo1;
      v_sdo  = v_sel ? sdo3  : sdo1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Wire position of the i-th transmitted bit within the byte.
   function automatic int unsigned wire_pos(input int unsigned i);
`ifdef SPI_LSB_FIRST_EN
      return i;
`else
      return 7 - i;
`endif
   endfunction

   // Whenever chip select is high both data lines must rest at 0.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cs1) begin
            check("idle_mosi1", mosi1, 1'b0);
            check("idle_miso1", miso1, 1'b0);
         end
         if (cs3) begin
            check("idle_mosi3", mosi3, 1'b0);
            check("idle_miso3", miso3, 1'b0);
         end
      end
   end

   // One frame observed cycle by cycle: sck pulse count, half-period lengths,
   // bit order on both data lines, frame length and the exchanged bytes.
   task automatic frame(input string tag, input logic s3, input logic [7:0] mtx,
                        input logic [7:0] stx, input int unsigned hold,
                        input logic [7:0] exp_sdo, input logic [7:0] exp_mdo);
      int unsigned hp = s3 ? 3 : 1;
      int unsigned cyc = 0, pulses = 0, run = 0, run_bad = 0;
      logic        prev = 1'b0, saw_low = 1'b0, done = 1'b0;
      logic [7:0]  mosi_acc = '0, miso_acc = '0;
      @(negedge clk);
      v_sel = s3;
      m_din = mtx;
      s_din = stx;
      if (s3) start3 = 1'b1;
      else    start1 = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         cyc++;
         if (cyc >= hold) begin
            start1 = 1'b0;
            start3 = 1'b0;
         end
         if (!v_cs) begin
            saw_low = 1'b1;
            if (v_sck != prev) begin
               if (run != hp) run_bad++;
               if (v_sck) begin
                  if (pulses < 8) begin
                     mosi_acc[wire_pos(pulses)] = v_mosi;
                     miso_acc[wire_pos(pulses)] = v_miso;
                  end
                  pulses++;
               end
               run = 1;
            end else begin
               run++;
            end
            prev = v_sck;
         end else if (saw_low) begin
            done = 1'b1;
         end
      end
      start1 = 1'b0;
      start3 = 1'b0;
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_cycles"}, cyc - 1, 16 * hp + 1);
      check({tag, "_pulses"}, pulses, 8);
      check({tag, "_halfper"}, run_bad, 0);
      check({tag, "_mosi_bits"}, mosi_acc, mtx);
      check({tag, "_miso_bits"}, miso_acc, stx);
      check({tag, "_mdo"}, v_mdo, exp_mdo);
      @(negedge clk);
      check({tag, "_sdo"}, v_sdo, exp_sdo);
   endtask

   typedef struct {
      string       tag;
      logic        s3;
      logic [7:0]  m_tx;
      logic [7:0]  s_tx;
      int unsigned hold;
      logic [7:0]  exp_sdo;
      logic [7:0]  exp_mdo;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{"a5",     1'b0, 8'hA5, 8'h5A, 1, 8'hA5, 8'h5A};
      vecs[1] = '{"b2b",    1'b0, 8'h3C, 8'hC3, 1, 8'h3C, 8'hC3};
      vecs[2] = '{"hold5",  1'b0, 8'h00, 8'hFF, 5, 8'h00, 8'hFF};
      vecs[3] = '{"x81",    1'b0, 8'h81, 8'h7E, 1, 8'h81, 8'h7E};
      vecs[4] = '{"hp3_ff", 1'b1, 8'hFF, 8'h00, 1, 8'hFF, 8'h00};
      vecs[5] = '{"hp3_5a", 1'b1, 8'h5A, 8'hA5, 1, 8'h5A, 8'hA5};

      // Reset state, while held and after release.
      #23;
      check("rst_cs1", cs1, 1'b1);
      check("rst_sck1", sck1, 1'b0);
      check("rst_mosi1", mosi1, 1'b0);
      check("rst_miso1", miso1, 1'b0);
      check("rst_mdo1", mdo1, 8'h00);
      check("rst_sdo1", sdo1, 8'h00);
      check("rst_cs3", cs3, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_cs1", cs1, 1'b1);
      check("idle_sck1", sck1, 1'b0);
      check("idle_mdo1", mdo1, 8'h00);
      check("idle_sdo1", sdo1, 8'h00);
      mon_en = 1'b1;

      for (int i = 0; i < 6; i++)
         frame(vecs[i].tag, vecs[i].s3, vecs[i].m_tx, vecs[i].s_tx,
               vecs[i].hold, vecs[i].exp_sdo, vecs[i].exp_mdo);

      // Random exchanges: each side ends up holding the byte the other sent.
      for (int i = 0; i < 16; i++) begin
         logic [7:0] mtx, stx;
         logic       s3;
         mtx = 8'($urandom);
         stx = 8'($urandom);
         s3  = 1'($urandom_range(0, 1));
         frame("rnd", s3, mtx, stx, 1, mtx, stx);
      end

      // Abort a frame with reset after the 4th sck pulse.
      begin
         int unsigned pulses = 0;
         logic        prev = 1'b0;
         v_sel = 1'b0;
         @(negedge clk);
         m_din  = 8'h96;
         s_din  = 8'h69;
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         for (int c = 0; c < 100; c++) begin
            if (sck1 && !prev) pulses++;
            prev = sck1;
            if (pulses == 4 && !sck1) break;
            @(negedge clk);
         end
         check("abort_reach4", pulses, 4);
         check("abort_cs_low", cs1, 1'b0);
         #2 rst = 1'b0;
         #1;
         check("abort_cs", cs1, 1'b1);
         check("abort_sck", sck1, 1'b0);
         check("abort_mosi", mosi1, 1'b0);
         check("abort_miso", miso1, 1'b0);
         check("abort_mdo", mdo1, 8'h00);
         check("abort_sdo", sdo1, 8'h00);
         @(negedge clk);
         rst = 1'b1;
         repeat (20) @(negedge clk);
         check("post_abort_cs", cs1, 1'b1);
         check("post_abort_mdo", mdo1, 8'h00);
         check("post_abort_sdo", sdo1, 8'h00);
         frame("clean", 1'b0, 8'h96, 8'h69, 1, 8'h96, 8'h69);
      end

      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Deliverable SHALL contain two modules, spi_master and its companion spi_slave, sharing one clock and one reset.
REQ-002 spi_master parameter: HALF_PERIOD, default 1, clk cycles per SCK half-period (legal range 1-255).
REQ-003 Both modules: clk  in  1  single system clock, all logic on rising edge.
REQ-004 Both modules: rst  in  1  asynchronous, active-low reset.
REQ-005 spi_master: start  in  1  one-cycle request to begin a transfer; ignored while busy.
REQ-006 spi_master: data_in  in  8  byte to transmit, latched on accepted start.
REQ-007 spi_master: data_out  out  8  last byte received on miso.
REQ-008 spi_master: sck  out  1  serial clock, idle low.
REQ-009 spi_master: mosi  out  1  serial data to slave.
REQ-010 spi_master: miso  in  1  serial data from slave.
REQ-011 spi_master: cs  out  1  chip select, active low.
REQ-012 spi_slave ports: sck, mosi, cs (in, 1); miso (out, 1); data_in (in, 8) reply byte; data_out (out, 8) last byte received.

Function
REQ-013 Protocol SHALL be SPI mode 0 (CPOL=0, CPHA=0), 8 bits per frame, MSB first; all sck/mosi/cs/miso outputs registered.
REQ-014 Master states SHALL be IDLE, XFER, DONE; IDLE->XFER on start, XFER->DONE after 8th sample, DONE->IDLE after one cycle.
REQ-015 On accepting start (cycle T0): latch data_in, drive cs=0, mosi=bit7, sck=0.
REQ-016 In XFER sck SHALL toggle every HALF_PERIOD cycles; on each 1->0 transition master samples miso into its shift register and drives next mosi bit.
REQ-017 After 8th sample, sck SHALL stay 0; in DONE master drives cs=1 and loads data_out with received byte.
REQ-018 With HALF_PERIOD=1 a frame SHALL take 17 cycles from start edge to cs=1.
REQ-019 start asserted during XFER or DONE SHALL be ignored; mosi SHALL be 0 in IDLE.
REQ-020 Slave SHALL detect sck and cs edges by comparing with registered previous values on clk.
REQ-021 On cs falling detect: slave loads data_in, drives miso=bit7, clears bit counter.
REQ-022 On sck rising detect with cs=0: slave samples mosi; on sck falling detect with cs=0: slave drives next miso bit.
REQ-023 On cs rising detect after exactly 8 samples, slave SHALL update data_out; fewer than 8 samples leaves data_out unchanged.
REQ-024 Slave miso SHALL be 0 whenever cs=1.

Reset
REQ-025 rst low SHALL immediately force: master IDLE, cs=1, sck=0, mosi=0, data_out=0x00; slave miso=0, data_out=0x00, counters and shift registers cleared.
REQ-026 Reset mid-frame SHALL abort the frame; no data_out update; next start after release begins a clean frame.

Configuration
REQ-027 Macro SPI_LSB_FIRST_EN defined: both modules transmit and receive LSB first; undefined: MSB first; timing identical.

Verification
REQ-028 Reset, then idle: cs=1, sck=0, mosi=0, miso=0, both data_out=0x00.
REQ-029 Master data_in=0xA5, slave data_in=0x5A, one start pulse -> within 20 cycles slave data_out=0xA5, master data_out=0x5A, exactly 8 sck pulses.
REQ-030 Back-to-back second frame 0x3C / 0xC3 -> slave data_out=0x3C, master data_out=0xC3.
REQ-031 start held high for 5 cycles during a frame -> only one frame, 8 sck pulses.
REQ-032 rst asserted after 4th sck pulse -> cs=1, sck=0 at once, both data_out unchanged from prior values/reset.
REQ-033 HALF_PERIOD=3, 0xFF/0x00 -> sck high and low 3 cycles each, slave data_out=0xFF, master data_out=0x00.
